l1_cache_sa: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate L1 data cache for the main CPU pipeline. It generalises set count, associativity and line size, and uses tree pseudo-LRU replacement. It adds a miss/refill FSM with dirty-line write-back to a word-serial memory port, valid/ready handshakes on both sides, and hit/miss performance counters.

---
 rtl/l1_cache_pkg.sv | 47 ++++
 rtl/l1_cache_sa_plru_tree.sv | 37 +++
 rtl/l1_cache_sa.sv | 238 +++++++++++++++++++++++
 tb/tb_l1_cache_sa.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_cache_pkg.sv
// Shared types and address-field helpers for the set-associative L1 data cache.
// Field widths are derived from SETS, WAYS and LINE_WORDS.
package l1_cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        REFILL    = 2'd3
    } state_t;

    function automatic int unsigned offset_bits(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int unsigned index_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned sets, input int unsigned line_words);
        return 32 - index_bits(sets) - offset_bits(line_words);
    endfunction

    // With WAYS=1 the way select and PLRU vectors keep a minimum width of one unused bit.
    function automatic int unsigned way_bits(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int unsigned plru_bits(input int unsigned ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] a, input int unsigned line_words);
        return (a >> 2) & (line_words - 1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned sets,
                                               input int unsigned line_words);
        return (a >> offset_bits(line_words)) & (sets - 1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned sets,
                                             input int unsigned line_words);
        return a >> (offset_bits(line_words) + index_bits(sets));
    endfunction

endpackage

// File: rtl/l1_cache_sa_plru_tree.sv
// Tree pseudo-LRU: victim walk and post-access bit update for one set.
// Node n has children 2n+1 (left, bit=0) and 2n+2 (right, bit=1); each bit points at the victim side.
module plru_tree
    import l1_cache_pkg::*;
#(
    parameter int unsigned WAYS = 2,
    localparam int unsigned WAY_W  = way_bits(WAYS),
    localparam int unsigned PLRU_W = plru_bits(WAYS)
) (
    input  logic [PLRU_W-1:0] bits_i,
    input  logic [WAY_W-1:0]  access_way_i,
    output logic [WAY_W-1:0]  victim_o,
    output logic [PLRU_W-1:0] bits_o
);

    localparam int unsigned LEVELS = (WAYS > 1) ? $clog2(WAYS) : 0;

    always_comb begin
        int unsigned node;
        logic        b;
        victim_o = '0;
        bits_o   = bits_i;
        node     = 0;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            b = bits_i[node];
            victim_o[LEVELS-1-l] = b;
            node = 2 * node + 1 + {31'd0, b};
        end
        node = 0;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            b = access_way_i[LEVELS-1-l];
            bits_o[node] = ~b;
            node = 2 * node + 1 + {31'd0, b};
        end
    end

endmodule

// File: rtl/l1_cache_sa.sv
// N-way set-associative write-back, write-allocate L1 data cache with a word-serial
// memory port, tree-PLRU replacement and saturating hit/miss counters.
module l1_cache_sa
    import l1_cache_pkg::*;
#(
    parameter int unsigned SETS       = 64,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IDX_W  = index_bits(SETS);
    localparam int unsigned TAG_W  = tag_bits(SETS, LINE_WORDS);
    localparam int unsigned WORD_W = offset_bits(LINE_WORDS) - 2;
    localparam int unsigned WAY_W  = way_bits(WAYS);
    localparam int unsigned PLRU_W = plru_bits(WAYS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                replay_q, replay_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [WORD_W-1:0]   wb_cnt_q, wb_cnt_d;
    logic [WORD_W:0]     iss_cnt_q, iss_cnt_d;
    logic [WORD_W-1:0]   rcv_cnt_q, rcv_cnt_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [31:0]         data_q  [SETS][WAYS][LINE_WORDS];
    logic [SETS-1:0][WAYS-1:0]   valid_q;
    logic [SETS-1:0][WAYS-1:0]   dirty_q;
    logic [SETS-1:0][PLRU_W-1:0] plru_q;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [WORD_W-1:0]   word;
    logic                hit, inv_found;
    logic [WAY_W-1:0]    hit_way, inv_way, plru_victim, miss_victim;
    logic [PLRU_W-1:0]   plru_upd;
    logic [31:0]         line_word, merged;
    logic                hit_upd, fill, install;

    assign idx  = IDX_W'(addr_index(addr_q, SETS, LINE_WORDS));
    assign tag  = TAG_W'(addr_tag(addr_q, SETS, LINE_WORDS));
    assign word = WORD_W'(addr_word(addr_q, LINE_WORDS));

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_i       (plru_q[idx]),
        .access_way_i (hit_way),
        .victim_o     (plru_victim),
        .bits_o       (plru_upd)
    );

    assign miss_victim = inv_found ? inv_way : plru_victim;
    assign line_word   = data_q[idx][hit_way][word];

    always_comb begin
        merged = line_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        replay_d   = replay_q;
        victim_d   = victim_q;
        wb_cnt_d   = wb_cnt_q;
        iss_cnt_d  = iss_cnt_q;
        rcv_cnt_d  = rcv_cnt_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        hit_upd    = 1'b0;
        fill       = 1'b0;
        install    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = req_addr;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    be_d     = req_be;
                    replay_d = 1'b0;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_rdata = we_q ? '0 : line_word;
                    hit_upd    = 1'b1;
                    if (!replay_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
                    replay_d   = 1'b0;
                    state_d    = IDLE;
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
                    victim_d  = miss_victim;
                    wb_cnt_d  = '0;
                    iss_cnt_d = '0;
                    rcv_cnt_d = '0;
                    state_d   = (valid_q[idx][miss_victim] && dirty_q[idx][miss_victim])
                                ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[idx][victim_q], idx, wb_cnt_q, 2'b00};
                mem_wdata = data_q[idx][victim_q][wb_cnt_q];
                if (mem_ready) begin
                    wb_cnt_d = wb_cnt_q + 1'b1;
                    if (wb_cnt_q == LAST_WORD) state_d = REFILL;
                end
            end
            REFILL: begin
                // Issue and receive advance independently; returns may overlap later issues.
                if (!iss_cnt_q[WORD_W]) begin
                    mem_valid = 1'b1;
                    mem_addr  = {tag, idx, iss_cnt_q[WORD_W-1:0], 2'b00};
                    if (mem_ready) iss_cnt_d = iss_cnt_q + 1'b1;
                end
                if (mem_rvalid) begin
                    fill      = 1'b1;
                    rcv_cnt_d = rcv_cnt_q + 1'b1;
                    if (rcv_cnt_q == LAST_WORD) begin
                        install  = 1'b1;
                        replay_d = 1'b1;
                        state_d  = LOOKUP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            replay_q   <= 1'b0;
            victim_q   <= '0;
            wb_cnt_q   <= '0;
            iss_cnt_q  <= '0;
            rcv_cnt_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
            plru_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            replay_q   <= replay_d;
            victim_q   <= victim_d;
            wb_cnt_q   <= wb_cnt_d;
            iss_cnt_q  <= iss_cnt_d;
            rcv_cnt_q  <= rcv_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if (hit_upd) begin
                plru_q[idx] <= plru_upd;
                if (we_q && be_q != '0) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (install) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hit_upd && we_q) data_q[idx][hit_way][word] <= merged;
        if (fill)            data_q[idx][victim_q][rcv_cnt_q] <= mem_rdata;
        if (install)         tag_q[idx][victim_q] <= tag;
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_l1_cache_sa.sv
// Directed bench for l1_cache_sa: miss/refill, hits, byte-merge writes, dirty and clean
// eviction, memory back-pressure mid-refill and reset mid-refill.
module tb_l1_cache_sa;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_we;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] hit_count, miss_count;

    always #5 clk = ~clk;

    l1_cache_sa #(.SETS(64), .WAYS(2), .LINE_WORDS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h1000) >> 2);
    endfunction

    // Memory model: decisions made on the falling edge, so they are stable for the next rising edge.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] rq_addr[$];
    int unsigned rq_due[$];
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          stall_at = -1;
    int unsigned stall_left = 0;
    bit          stall_done = 1'b0;
    logic [31:0] stall_exp_addr = '0;

    always @(negedge clk) begin
        if (!reset) begin
            rq_addr.delete();
            rq_due.delete();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            mem_ready  = 1'b1;
            stall_left = 0;
        end else begin
            if (stall_at >= 0 && !stall_done && rd_log.size() == stall_at) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
                check("stall_mem_valid", {31'd0, mem_valid}, 32'd1);
                check("stall_mem_addr", mem_addr, stall_exp_addr);
            end else begin
                mem_ready = 1'b1;
            end
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(rq_addr.pop_front());
                void'(rq_due.pop_front());
            end
            if (mem_valid && mem_ready) begin
                if (mem_we) begin
                    wr_addr_log.push_back(mem_addr);
                    wr_data_log.push_back(mem_wdata);
                end else begin
                    rd_log.push_back(mem_addr);
                    rq_addr.push_back(mem_addr);
                    rq_due.push_back(cyc + 2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd, output int unsigned lat);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 300) begin
            tick();
            lat++;
        end
        if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
        rd = resp_rdata;
        tick();
    endtask

    task automatic check_rd_beats(input string tag, input logic [31:0] base);
        check({tag, "_rd_beats"}, 32'(rd_log.size()), 32'd8);
        for (int i = 0; i < rd_log.size() && i < 8; i++)
            check({tag, "_rd_addr"}, rd_log[i], base + 32'(4 * i));
    endtask

    initial begin
        logic [31:0] rd;
        int unsigned lat;
        int unsigned w;

        // Reset values
        #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        do_reset();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Scenario 1: cold miss then hit in the same line
        do_req(1'b0, 32'h1000, '0, '0, rd, lat);
        check("s1_rdata", rd, 32'h0000_00A0);
        check("s1_miss", miss_count, 32'd1);
        check("s1_hit", hit_count, 32'd0);
        check_rd_beats("s1", 32'h1000);
        check("s1_wr_beats", 32'(wr_addr_log.size()), 32'd0);
        clear_logs();
        do_req(1'b0, 32'h1004, '0, '0, rd, lat);
        check("s1_hit_lat", lat, 32'd1);
        check("s1_hit_rdata", rd, 32'h0000_00A1);
        check("s1_hit_count", hit_count, 32'd1);
        check("s1_hit_no_mem", 32'(rd_log.size() + wr_addr_log.size()), 32'd0);

        // Scenario 2: partial-byte write merge; be=0 is a counted no-op
        do_req(1'b1, 32'h1008, 32'hDEAD_BEEF, 4'b0011, rd, lat);
        check("s2_wr_lat", lat, 32'd1);
        do_req(1'b0, 32'h1008, '0, '0, rd, lat);
        check("s2_merge", rd, 32'h0000_BEEF);
        do_req(1'b1, 32'h1004, 32'h1234_5678, 4'b0000, rd, lat);
        check("s2_be0_lat", lat, 32'd1);
        do_req(1'b0, 32'h1004, '0, '0, rd, lat);
        check("s2_be0_data", rd, 32'h0000_00A1);
        check("s2_hit_count", hit_count, 32'd5);
        check("s2_miss_count", miss_count, 32'd1);

        // Scenario 3: dirty eviction of the PLRU way
        do_reset();
        do_req(1'b0, 32'h1800, '0, '0, rd, lat);
        check("s3_fill_a", rd, 32'h0000_02A0);
        do_req(1'b0, 32'h1000, '0, '0, rd, lat);
        check("s3_fill_b", rd, 32'h0000_00A0);
        do_req(1'b1, 32'h1008, 32'hDEAD_BEEF, 4'b0011, rd, lat);
        do_req(1'b0, 32'h1800, '0, '0, rd, lat);
        check("s3_touch_a", rd, 32'h0000_02A0);
        clear_logs();
        do_req(1'b0, 32'h2000, '0, '0, rd, lat);
        check("s3_rdata", rd, 32'h0000_04A0);
        check("s3_wr_beats", 32'(wr_addr_log.size()), 32'd8);
        for (int i = 0; i < wr_addr_log.size() && i < 8; i++) begin
            check("s3_wr_addr", wr_addr_log[i], 32'h1000 + 32'(4 * i));
            check("s3_wr_data", wr_data_log[i], (i == 2) ? 32'h0000_BEEF : 32'hA0 + 32'(i));
        end
        check_rd_beats("s3", 32'h2000);
        check("s3_miss", miss_count, 32'd3);
        check("s3_hit", hit_count, 32'd2);
        clear_logs();
        do_req(1'b0, 32'h1804, '0, '0, rd, lat);
        check("s3_survivor_lat", lat, 32'd1);
        check("s3_survivor", rd, 32'h0000_02A1);

        // Scenario 4: clean eviction, no write-back
        do_reset();
        do_req(1'b0, 32'h1800, '0, '0, rd, lat);
        do_req(1'b0, 32'h1000, '0, '0, rd, lat);
        do_req(1'b0, 32'h1800, '0, '0, rd, lat);
        clear_logs();
        do_req(1'b0, 32'h2000, '0, '0, rd, lat);
        check("s4_rdata", rd, 32'h0000_04A0);
        check("s4_wr_beats", 32'(wr_addr_log.size()), 32'd0);
        check_rd_beats("s4", 32'h2000);
        check("s4_miss", miss_count, 32'd3);

        // Scenario 5: memory back-pressure mid-refill
        clear_logs();
        stall_exp_addr = 32'h300C;
        stall_done = 1'b0;
        stall_at = 3;
        do_req(1'b0, 32'h3000, '0, '0, rd, lat);
        stall_at = -1;
        check("s5_stall_seen", {31'd0, stall_done}, 32'd1);
        check("s5_rdata", rd, 32'h0000_08A0);
        check_rd_beats("s5", 32'h3000);
        do_req(1'b0, 32'h301C, '0, '0, rd, lat);
        check("s5_last_word", rd, 32'h0000_08A7);

        // Scenario 6: reset during the 4th refill beat
        clear_logs();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h4000;
        tick();
        req_valid = 1'b0;
        w = 0;
        while (rd_log.size() < 4 && w < 200) begin
            tick();
            w++;
        end
        check("s6_reach_beat4", {31'd0, rd_log.size() >= 4}, 32'd1);
        reset = 1'b0;
        #1;
        check("s6_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("s6_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("s6_mem_addr", mem_addr, 32'd0);
        check("s6_miss_count", miss_count, 32'd0);
        check("s6_hit_count", hit_count, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("s6_req_ready", {31'd0, req_ready}, 32'd1);
        clear_logs();
        do_req(1'b0, 32'h4000, '0, '0, rd, lat);
        check("s6_rdata", rd, 32'h0000_0CA0);
        check("s6_remiss", miss_count, 32'd1);
        check_rd_beats("s6", 32'h4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
